// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan display.
// The segment table is active-high; the display polarity is applied by seg_polarity().
package seg_pkg;

    localparam int NDIG = 8;

    localparam logic [7:0] SEG_OFF_AL = 8'hFF;
    localparam logic [7:0] SEG_OFF_AH = 8'h00;

    // Bit order is {g,f,e,d,c,b,a}, indexed by the hex nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
    } disp_word_t;

    function automatic logic [7:0] seg_polarity(input logic [7:0] pattern, input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg_scan_display_dec.sv
// Combinational hex digit decoder: nibble plus decimal point to an active-high
// segment byte {dp,g,f,e,d,c,b,a}.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern = {dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit hex display. A captured value waits in a pending
// register and is only committed at a frame boundary so a scan never tears.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic        data_vld,
    output logic [7:0]  seg,
    output logic [2:0]  which,
    output logic        frame_done
);

    localparam int         CNT_W   = $clog2(SCAN_DIV);
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;

    logic [CNT_W-1:0] presc_q;
    logic             tick;
    logic             boundary;
    logic [2:0]       which_q;
    logic [2:0]       which_d;
    disp_word_t       pend_q;
    logic             pend_flag_q;
    disp_word_t       shadow_q;
    disp_word_t       shadow_d;
    logic             frame_done_q;
    logic [7:0]       seg_q;
    logic [7:0]       seg_d;
    logic [3:0]       nibble;
    logic             dp_bit;
    logic [31:0]      upper;
    logic             blank;
    logic [7:0]       raw_pattern;

    assign tick     = (presc_q == CNT_W'(SCAN_DIV - 1));
    assign boundary = tick && (which_q == 3'(NDIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + CNT_W'(1);
        end
    end

    assign which_d = tick ? (which_q + 3'd1) : which_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            which_q      <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            which_q      <= which_d;
            frame_done_q <= boundary;
        end
    end

    // A strobe landing on the boundary bypasses pending and commits directly
    always_comb begin
        shadow_d = shadow_q;
        if (boundary) begin
            if (data_vld) begin
                shadow_d.value = data;
                shadow_d.dp    = dp_in;
            end else if (pend_flag_q) begin
                shadow_d = pend_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            shadow_q    <= '0;
        end else begin
            if (data_vld) begin
                pend_q.value <= data;
                pend_q.dp    <= dp_in;
            end
            if (boundary) begin
                pend_flag_q <= 1'b0;
            end else if (data_vld) begin
                pend_flag_q <= 1'b1;
            end
            shadow_q <= shadow_d;
        end
    end

    // Segment data is computed from the next digit index and next shadow so
    // seg and which always change together on the tick edge.
    assign nibble = shadow_d.value[{which_d, 2'b00} +: 4];
    assign dp_bit = shadow_d.dp[which_d];
    assign upper  = shadow_d.value >> {which_d, 2'b00};
    assign blank  = BLANK_LZ && (which_d != 3'd0) && (upper == '0);

    hex7seg_dec u_dec (
        .nibble  (nibble),
        .dp      (dp_bit),
        .pattern (raw_pattern)
    );

    assign seg_d = blank ? SEG_OFF : seg_polarity(raw_pattern, SEG_ACTIVE_LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
        end else if (tick) begin
            seg_q <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign which      = which_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with SCAN_DIV=4, leading-zero blanking
// and active-low segments, compared against a cycle-count based reference model.
module tb_seg_scan_display;

    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [31:0] data     = '0;
    logic [7:0]  dp_in    = '0;
    logic        data_vld = 1'b0;
    logic [7:0]  seg;
    logic [2:0]  which;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .SCAN_DIV       (SD),
        .BLANK_LZ       (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_in      (dp_in),
        .data_vld   (data_vld),
        .seg        (seg),
        .which      (which),
        .frame_done (frame_done)
    );

    // Reference model: everything follows from the number of clock edges since reset
    logic [6:0]  ref_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          cyc       = 0;
    logic [31:0] m_val     = '0;
    logic [7:0]  m_dp      = '0;
    logic [31:0] lat_val   = '0;
    logic [7:0]  lat_dp    = '0;
    bit          have      = 1'b0;
    int          exp_which = 0;
    logic        exp_fd    = 1'b0;
    logic [7:0]  exp_seg   = 8'hFF;

    function automatic logic [7:0] ref_seg(input logic [31:0] v, input logic [7:0] dp, input int d);
        if (d != 0 && (v >> (4 * d)) == 32'd0) return 8'hFF;
        return ~{dp[d], ref_tbl[v[4 * d +: 4]]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_val = '0; m_dp = '0; have = 1'b0;
            exp_which = 0; exp_fd = 1'b0; exp_seg = 8'hFF;
        end else begin
            cyc++;
            if (data_vld) begin
                lat_val = data; lat_dp = dp_in; have = 1'b1;
            end
            if (cyc % FRAME == 0) begin
                if (have) begin
                    m_val = lat_val; m_dp = lat_dp;
                end
                have = 1'b0;
            end
            exp_which = (cyc / SD) % 8;
            exp_fd    = (cyc % FRAME == 0);
            exp_seg   = (cyc < SD) ? 8'hFF : ref_seg(m_val, m_dp, exp_which);
        end
    end

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != ph; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; data_vld = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 8'hFF) begin failures++; $display("[TB] FAIL reset_seg got=%h exp=%h", seg, 8'hFF); end
        checks++;
        if (which !== 3'd0) begin failures++; $display("[TB] FAIL reset_which got=%0d exp=0", which); end
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_fd got=%b exp=0", frame_done); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int pulses = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            checks++;
            if (which !== exp_which[2:0] || seg !== exp_seg || frame_done !== exp_fd) begin
                failures++;
                $display("[TB] FAIL scan cyc=%0d which=%0d/%0d seg=%h/%h fd=%b/%b",
                         cyc, which, exp_which, seg, exp_seg, frame_done, exp_fd);
            end
            if (frame_done) pulses++;
        end
        checks++;
        if (pulses != 2) begin failures++; $display("[TB] FAIL scan_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_mid_frame();
        bit committed = 1'b0;
        logic [7:0] want;
        wait_phase(12);
        data = 32'h0000_0008; dp_in = 8'h00; data_vld = 1'b1;
        repeat (40) begin
            @(negedge clk);
            data_vld = 1'b0;
            if (cyc % FRAME == 0) committed = 1'b1;
            want = ((cyc % FRAME) / SD != 0) ? 8'hFF : (committed ? 8'h80 : 8'hC0);
            checks++;
            if (seg !== want || seg !== exp_seg || which !== exp_which[2:0]) begin
                failures++;
                $display("[TB] FAIL mid_frame cyc=%0d seg=%h exp=%h model=%h which=%0d/%0d",
                         cyc, seg, want, exp_seg, which, exp_which);
            end
        end
    endtask

    task automatic test_deadbeef();
        logic [7:0] beef_tab [8] = '{8'h8E, 8'h86, 8'h86, 8'h83, 8'hA1, 8'h88, 8'h86, 8'hA1};
        wait_phase(5);
        data = 32'hDEAD_BEEF; dp_in = 8'h00; data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
        wait_phase(FRAME - 1);
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if (seg !== beef_tab[(cyc % FRAME) / SD] || which !== exp_which[2:0]) begin
                failures++;
                $display("[TB] FAIL deadbeef cyc=%0d which=%0d seg=%h exp=%h",
                         cyc, which, seg, beef_tab[(cyc % FRAME) / SD]);
            end
        end
    endtask

    task automatic test_back_to_back();
        wait_phase(3);
        data = 32'h1; data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
        repeat (5) @(negedge clk);
        data = 32'h2; data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
        wait_phase(FRAME - 1);
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if ((((cyc % FRAME) / SD == 0) && seg !== 8'hA4) || seg !== exp_seg) begin
                failures++;
                $display("[TB] FAIL last_wins cyc=%0d seg=%h exp=%h", cyc, seg, exp_seg);
            end
        end
        wait_phase(FRAME - 1);
        data = 32'h3; data_vld = 1'b1;
        @(posedge clk);
        #1;
        data_vld = 1'b0;
        checks++;
        if (which !== 3'd0 || seg !== 8'hB0 || frame_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL boundary_strobe which=%0d seg=%h fd=%b exp which=0 seg=b0 fd=1",
                     which, seg, frame_done);
        end
        repeat (FRAME + 4) begin
            @(negedge clk);
            checks++;
            if (seg !== exp_seg || which !== exp_which[2:0]) begin
                failures++;
                $display("[TB] FAIL after_boundary cyc=%0d seg=%h exp=%h", cyc, seg, exp_seg);
            end
        end
    endtask

    task automatic test_dp();
        wait_phase(10);
        data = 32'h0; dp_in = 8'h01; data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0; dp_in = 8'h00;
        wait_phase(FRAME - 1);
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if (seg !== ((((cyc % FRAME) / SD) == 0) ? 8'h40 : 8'hFF)) begin
                failures++;
                $display("[TB] FAIL dp_blank cyc=%0d which=%0d seg=%h", cyc, which, seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_phase(6);
        data = 32'h5; data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (seg !== 8'hFF || which !== 3'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset seg=%h which=%0d fd=%b exp seg=ff which=0 fd=0",
                     seg, which, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            checks++;
            if (seg !== exp_seg || which !== exp_which[2:0] ||
                (cyc >= FRAME && (cyc % FRAME) < SD && seg !== 8'hC0)) begin
                failures++;
                $display("[TB] FAIL post_reset cyc=%0d seg=%h exp=%h which=%0d/%0d",
                         cyc, seg, exp_seg, which, exp_which);
            end
        end
    endtask

    task automatic test_random();
        repeat (6 * FRAME) begin
            @(negedge clk);
            checks++;
            if (which !== exp_which[2:0] || seg !== exp_seg || frame_done !== exp_fd) begin
                failures++;
                $display("[TB] FAIL random cyc=%0d which=%0d/%0d seg=%h/%h fd=%b/%b",
                         cyc, which, exp_which, seg, exp_seg, frame_done, exp_fd);
            end
            data_vld = ($urandom_range(0, 11) == 0);
            data     = $urandom >> (4 * $urandom_range(0, 7));
            dp_in    = 8'($urandom);
        end
        data_vld = 1'b0;
        repeat (FRAME + 8) begin
            @(negedge clk);
            checks++;
            if (which !== exp_which[2:0] || seg !== exp_seg || frame_done !== exp_fd) begin
                failures++;
                $display("[TB] FAIL random_drain cyc=%0d seg=%h/%h", cyc, seg, exp_seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_mid_frame();
        test_deadbeef();
        test_back_to_back();
        test_dp();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout cyc=%0d", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream display stage for the multi-function ALU. Captures a 32-bit value (ALU result F) on a valid strobe and scans it as 8 hex digits on a time-multiplexed 7-segment display.
- Drives the board-level seg[7:0] / which[2:0] pins.
- Double-buffers the value so the display only changes at a frame boundary, which prevents tearing.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (must be >= 2; benches use 4).
- BLANK_LZ, 1, when 1, blank leading-zero digits (digit 0 is never blanked).
- SEG_ACTIVE_LOW, 1, when 1, seg outputs are inverted (segment lit = 0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data  in  32  value to display (ALU result).
- dp_in  in  8  decimal point per digit, captured together with data.
- data_vld  in  1  1-cycle strobe that captures data/dp_in into the pending register.
- seg  out  8  segment drive: seg[0]=a .. seg[6]=g, seg[7]=dp. Polarity set by SEG_ACTIVE_LOW.
- which  out  3  active digit index; 0 = least significant nibble.
- frame_done  out  1  1-cycle pulse when a full 8-digit scan completes.

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, which=0, frame_done=0.
  - shadow=0, pending=0, pend_flag=0, dp shadow=0.
  - seg=all-off (8'hFF if SEG_ACTIVE_LOW, else 8'h00).
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where the count equals SCAN_DIV-1.
- On tick: which increments, wrapping 7->0. boundary = tick && which==7.
- frame_done is a registered pulse, high for exactly one cycle, coincident with which becoming 0. Period = 8*SCAN_DIV cycles.
- Capture:
  - data_vld loads pending<=data, pend_dp<=dp_in, pend_flag<=1.
  - Several strobes within one frame: the last one wins.
- Commit, on boundary:
  - If pend_flag: shadow<=pending, dp shadow<=pend_dp, pend_flag<=0.
  - If data_vld coincides with boundary, the incoming data/dp_in go straight to shadow and pend_flag ends 0.
- Output timing:
  - seg and which are registered and update on the same edge.
  - seg always corresponds to the which value it appears with.
  - On the boundary edge, seg reflects the newly committed shadow (digit 0).
- Decode:
  - nibble = shadow[4*which +: 4].
  - Active-high patterns: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - seg[7] = dp shadow[which].
  - Invert the whole byte when SEG_ACTIVE_LOW.
- Blanking: when BLANK_LZ=1, digit i (i>=1) is blank if shadow[31:4i]==0. A blank digit outputs all-off, dp included.
- Between ticks, all outputs hold.
- Reset mid-operation discards pending data; the display restarts at which=0 with value 0.

Decomposition:
- Package seg_pkg:
  - NDIG=8.
  - 16-entry hex-to-segment constant table.
  - SEG_OFF constants for both polarities.
  - Function for the polarity-applied pattern.
- Sub-module hex7seg_dec: combinational, nibble + dp -> active-high 8-bit pattern.
- Top keeps the prescaler, digit counter, pending/shadow registers, blanking logic and output registers.

Test Plan (SCAN_DIV=4, BLANK_LZ=1, SEG_ACTIVE_LOW=1):
1. Hold rst=1 -> seg=8'hFF, which=0, frame_done=0. After release, which steps 0,1,..7,0 every 4 clk and frame_done pulses once per 32 clk.
2. Mid-frame data_vld with data=32'h00000008 (5+3):
   - Until the boundary, digit0 stays 8'hC0 and digits 1-7 stay 8'hFF.
   - From the next which=0 onward, digit0=8'h80 and digits 1-7=8'hFF.
3. data=32'hDEADBEEF committed -> which 0..7 shows 8E,86,86,83,A1,88,86,A1.
4. Two strobes in one frame (data=1, then data=2) -> only 8'hA4 appears on digit0. A strobe exactly on the boundary cycle (data=3) -> digit0=8'hB0 in the very next cycle, with which=0.
5. dp_in=8'h01 with data=0 -> digit0 seg=8'h40, digits 1-7=8'hFF (blanked, dp suppressed).
6. Pending data=32'h5 followed by async rst mid-frame -> immediately seg=8'hFF, which=0. After release, digit0=8'hC0; value 5 is never shown.
